// File: rtl/inverse_fixpoint_serializer.sv
// Walks an N*N matrix of numerator/denominator pairs and streams each as signed fixed point
// via a serial restoring divider. Optional INVSER_ROUND_NEAREST_EN adds round-half-away-from-zero.
module inverse_fixpoint_serializer #(
  parameter int N         = 5,
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [4:0]       elem_addr,
  input  logic [WIDTH-1:0] elem_num,
  input  logic [WIDTH-1:0] elem_den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_addr,
  output logic             busy,
  output logic             done,
  output logic             dz_flag
);

`ifdef INVSER_ROUND_NEAREST_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int NE   = N * N;
  localparam int DIVB = WIDTH + FRAC_BITS + RND;
  localparam int MW   = WIDTH + FRAC_BITS + 1;
  localparam int CW   = $clog2(DIVB + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DIV, FIX, OUT, DONE} state_t;

  state_t            state_reg;
  logic [DIVB-1:0]   quo_reg;
  logic [WIDTH:0]    rem_reg;
  logic [WIDTH-1:0]  dsr_reg;
  logic [CW-1:0]     cnt_reg;
  logic              neg_reg;
  logic              dz_elem_reg;
  logic              num_neg_reg;
  logic              num_zero_reg;

  // Magnitudes are unsigned, so |-2^(WIDTH-1)| is representable without overflow.
  logic [WIDTH-1:0]  num_mag;
  logic [WIDTH-1:0]  den_mag;
  logic [WIDTH:0]    rem_shift;
  logic [WIDTH:0]    rem_sub;
  logic              q_bit;
  logic [MW-1:0]     mag;
  logic [MW-1:0]     min_mag;
  logic [WIDTH-1:0]  pos_max;
  logic [WIDTH-1:0]  neg_min;
  logic [WIDTH-1:0]  fix_result;

  always_comb begin
    num_mag   = elem_num[WIDTH-1] ? (~elem_num + 1'b1) : elem_num;
    den_mag   = elem_den[WIDTH-1] ? (~elem_den + 1'b1) : elem_den;
    rem_shift = {rem_reg[WIDTH-1:0], quo_reg[DIVB-1]};
    q_bit     = (rem_shift >= {1'b0, dsr_reg});
    rem_sub   = rem_shift - {1'b0, dsr_reg};
`ifdef INVSER_ROUND_NEAREST_EN
    mag = MW'(quo_reg[DIVB-1:1]) + MW'(quo_reg[0]);
`else
    mag = MW'(quo_reg);
`endif
    min_mag = MW'(1) << (WIDTH - 1);
    pos_max = {1'b0, {(WIDTH-1){1'b1}}};
    neg_min = {1'b1, {(WIDTH-1){1'b0}}};
    if (dz_elem_reg)
      fix_result = num_zero_reg ? '0 : (num_neg_reg ? neg_min : pos_max);
    else if (mag >= min_mag)
      fix_result = neg_reg ? neg_min : pos_max;
    else
      fix_result = neg_reg ? (~mag[WIDTH-1:0] + 1'b1) : mag[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      elem_addr    <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_addr     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dz_flag      <= 1'b0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      dsr_reg      <= '0;
      cnt_reg      <= '0;
      neg_reg      <= 1'b0;
      dz_elem_reg  <= 1'b0;
      num_neg_reg  <= 1'b0;
      num_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            dz_flag   <= 1'b0;
            elem_addr <= '0;
            busy      <= 1'b1;
            state_reg <= FETCH;
          end
        end
        FETCH: begin
          neg_reg      <= elem_num[WIDTH-1] ^ elem_den[WIDTH-1];
          num_neg_reg  <= elem_num[WIDTH-1];
          num_zero_reg <= (elem_num == '0);
          dz_elem_reg  <= (elem_den == '0);
          quo_reg      <= DIVB'(num_mag) << (FRAC_BITS + RND);
          rem_reg      <= '0;
          dsr_reg      <= den_mag;
          cnt_reg      <= CW'(DIVB - 1);
          if (elem_den == '0) begin
            dz_flag   <= 1'b1;
            state_reg <= FIX;
          end else begin
            state_reg <= DIV;
          end
        end
        DIV: begin
          // Quotient bits shift in from the LSB as dividend bits leave the MSB.
          rem_reg <= q_bit ? rem_sub : rem_shift;
          quo_reg <= {quo_reg[DIVB-2:0], q_bit};
          if (cnt_reg == '0)
            state_reg <= FIX;
          else
            cnt_reg <= cnt_reg - 1'b1;
        end
        FIX: begin
          out_data  <= fix_result;
          out_addr  <= elem_addr;
          out_valid <= 1'b1;
          state_reg <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (elem_addr == 5'(NE - 1)) begin
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              elem_addr <= elem_addr + 1'b1;
              state_reg <= FETCH;
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
